act_lm_bank: RTL and testbench
==============================

ACT_LM_BANK -- requirements
Module: act_lm_bank

Interface
REQ-001 Parameter CH, default 4: number of independent logic-module channels (1..16).
REQ-002 Parameter SEL_W, default 2: select bits per channel; truth table width TW = 2**SEL_W (SEL_W 1..4).
REQ-003 Derived constant W_CH = TW+2: config bits per channel; CFG_LEN = CH*W_CH.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port clr, input, 1: reset, synchronous, active-low.
REQ-006 Port a, input, CH*SEL_W: first operand of each select gate; channel c uses bits [c*SEL_W +: SEL_W].
REQ-007 Port b, input, CH*SEL_W: second operand of each select gate, same packing as a.
REQ-008 Port cfg_en, input, 1: shift-enable for the serial configuration chain.
REQ-009 Port cfg_in, input, 1: serial configuration data in.
REQ-010 Port cfg_out, output, 1: serial configuration data out (MSB of chain), for daisy-chaining banks.
REQ-011 Port cfg_valid, output, 1: high when a complete configuration is loaded.
REQ-012 Port out, output, CH: per-channel logic-module result.

Function
REQ-013 Select bit k of channel c: sel[k] = a[k] AND b[k] for even k, a[k] OR b[k] for odd k.
REQ-014 Mux result m[c] = table_c[sel], table_c = chain[c*W_CH +: TW]; mode_c = chain[c*W_CH+TW +: 2].
REQ-015 Chain shift: when cfg_en=1, chain <= {chain[CFG_LEN-2:0], cfg_in} each cycle; cfg_out = chain[CFG_LEN-1] combinationally.
REQ-016 Load counter: increments on each cfg_en=1 cycle, saturates at CFG_LEN; cfg_valid = (count == CFG_LEN), registered.
REQ-017 First cfg_en=1 cycle after a cycle with cfg_en=0 resets count to 1 (restart); cfg_valid drops the same edge.
REQ-018 Mode 00 COMB: out[c] = m[c] combinationally, gated by cfg_valid.
REQ-019 Mode 01 DFF: q[c] <= m[c]; out[c] = q[c]; one-cycle latency.
REQ-020 Mode 10 TFF: q[c] <= q[c] XOR m[c].
REQ-021 Mode 11 STICKY: q[c] <= q[c] OR m[c]; clears only on reset or reconfiguration.
REQ-022 While cfg_en=1 or cfg_valid=0: q held at 0, out = 0 for all channels, regardless of mode.
REQ-023 cfg_valid rising edge: q starts at 0; first functional update on the following edge.
REQ-024 Changes to a/b in COMB mode propagate to out in the same cycle; no glitch-filtering required.

Reset
REQ-025 clr=0 at a rising edge: chain, count, q cleared to 0; cfg_valid=0, out=0, cfg_out=0 from the next cycle.
REQ-026 clr=0 dominates cfg_en=1 on the same edge; a shift in progress is discarded and must be restarted.
REQ-027 No asynchronous behaviour; clr sampled only on clk rising edge.

Structure
REQ-028 Package act_pkg holds mode encoding (COMB, DFF, TFF, STICKY) as a 2-bit typedef and the W_CH/CFG_LEN width functions.
REQ-029 One sub-module act_lm_cell (select gates, TW:1 mux, mode-dependent flop) instantiated CH times; chain and counter live in act_lm_bank.
REQ-030 Target size 150-300 RTL lines total.

Verification
REQ-031 CH=4, SEL_W=2; shift 24 bits setting all channels DFF, table 4'b1000; a=b=all ones -> cfg_valid=1 after 24th shift edge, out=4'b1111 one cycle later.
REQ-032 Channel 0 TFF, table 4'b1111, any a/b -> out[0] toggles 0,1,0,1 on successive edges after cfg_valid.
REQ-033 Channel 1 STICKY, table 4'b0010; pulse a[2]=b[2]=1 (sel=01) one cycle, then sel=00 -> out[1] goes 1 and stays 1.
REQ-034 Channel 2 COMB, table 4'b0100; set a[5]=1 (sel=10) -> out[2]=1 same cycle; clear -> 0 same cycle.
REQ-035 Assert cfg_en mid-operation for 3 cycles -> cfg_valid=0 and out=0 next edge; cfg_out reproduces bits shifted in 24 cycles earlier.
REQ-036 clr=0 with cfg_en=1 on shift 12 -> count=0, cfg_valid=0, cfg_out=0; full 24-bit reload then restores REQ-031 result.

Source files
------------

// File: rtl/act_pkg.sv
// Shared definitions for the logic-module bank: mode encoding and chain sizing.
package act_pkg;

   // Per-channel operating mode, held in the top two config bits of each channel
   typedef enum logic [1:0] {
      MODE_COMB   = 2'b00,
      MODE_DFF    = 2'b01,
      MODE_TFF    = 2'b10,
      MODE_STICKY = 2'b11
   } act_mode_e;

   // Config bits per channel: truth table of 2**sel_w entries plus 2 mode bits
   function automatic int act_w_ch(input int sel_w);
      return (32'd1 << sel_w) + 32'd2;
   endfunction

   // Total configuration chain length for a bank of ch channels
   function automatic int act_cfg_len(input int ch, input int sel_w);
      return ch * act_w_ch(sel_w);
   endfunction

endpackage

// File: rtl/act_lm_cell.sv
// One logic-module channel: select gates, truth-table mux and mode-dependent flop.
module act_lm_cell
   import act_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      en,
   input  logic [SEL_W-1:0]          a,
   input  logic [SEL_W-1:0]          b,
   input  logic [(1 << SEL_W)-1:0]   tbl,
   input  logic [1:0]                mode,
   output logic                      out
);
   logic [SEL_W-1:0] sel_s;
   logic             m_s;
   logic             state_d;
   logic             state_q;
   act_mode_e        mode_s;

   assign mode_s = act_mode_e'(mode);

   // Select gates (AND on even bits, OR on odd bits) feeding the truth-table mux
   always_comb begin
      sel_s = '0;
      for (int k = 0; k < SEL_W; k++) begin
         if (k[0] == 1'b0) begin
            sel_s[k] = a[k] & b[k];
         end else begin
            sel_s[k] = a[k] | b[k];
         end
      end
      m_s = tbl[sel_s];
   end

   // Next flop state; held at zero whenever the bank is not running
   always_comb begin
      state_d = 1'b0;
      if (!en) begin
         state_d = 1'b0;
      end else begin
         case (mode_s)
            MODE_COMB:   state_d = 1'b0;
            MODE_DFF:    state_d = m_s;
            MODE_TFF:    state_d = state_q ^ m_s;
            MODE_STICKY: state_d = state_q | m_s;
            default:     state_d = 1'b0;
         endcase
      end
   end

   // Channel state flop with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= 1'b0;
      end else begin
         state_q <= state_d;
      end
   end

   // Output select: mux result directly in COMB mode, flop otherwise, forced low when idle
   always_comb begin
      out = 1'b0;
      if (!en) begin
         out = 1'b0;
      end else if (mode_s == MODE_COMB) begin
         out = m_s;
      end else begin
         out = state_q;
      end
   end

endmodule

// File: rtl/act_lm_bank.sv
// Bank of CH logic-module channels sharing one serial configuration chain.
module act_lm_bank
   import act_pkg::*;
#(
   parameter int CH    = 4,
   parameter int SEL_W = 2
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [CH*SEL_W-1:0]  a,
   input  logic [CH*SEL_W-1:0]  b,
   input  logic                 cfg_en,
   input  logic                 cfg_in,
   output logic                 cfg_out,
   output logic                 cfg_valid,
   output logic [CH-1:0]        out
);
   localparam int TW      = 1 << SEL_W;
   localparam int W_CH    = act_w_ch(SEL_W);
   localparam int CFG_LEN = act_cfg_len(CH, SEL_W);
   localparam int CNT_W   = $clog2(CFG_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

   logic [CFG_LEN-1:0] chain_d, chain_q;
   logic [CNT_W-1:0]   count_d, count_q;
   logic               valid_d, valid_q;
   logic               prev_en_d, prev_en_q;
   logic               run_s;

   // Chain shift and load counter; a new shift burst restarts the count at one
   always_comb begin
      chain_d   = chain_q;
      count_d   = count_q;
      prev_en_d = cfg_en;
      if (cfg_en) begin
         chain_d = {chain_q[CFG_LEN-2:0], cfg_in};
         if (!prev_en_q) begin
            count_d = CNT_ONE;
         end else if (count_q < CNT_MAX) begin
            count_d = count_q + CNT_ONE;
         end else begin
            count_d = count_q;
         end
      end else begin
         chain_d = chain_q;
         count_d = count_q;
      end
      valid_d = (count_d == CNT_MAX);
   end

   // Configuration state registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!clr) begin
         chain_q   <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         prev_en_q <= 1'b0;
      end else begin
         chain_q   <= chain_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         prev_en_q <= prev_en_d;
      end
   end

   // Channels only run with a complete configuration and no shift in progress
   assign run_s     = valid_q & ~cfg_en;
   assign cfg_out   = chain_q[CFG_LEN-1];
   assign cfg_valid = valid_q;

   for (genvar c = 0; c < CH; c++) begin : g_cell
      act_lm_cell #(.SEL_W(SEL_W)) u_cell (
         .clk  (clk),
         .clr  (clr),
         .en   (run_s),
         .a    (a[c*SEL_W +: SEL_W]),
         .b    (b[c*SEL_W +: SEL_W]),
         .tbl  (chain_q[c*W_CH +: TW]),
         .mode (chain_q[c*W_CH+TW +: 2]),
         .out  (out[c])
      );
   end

endmodule

// File: tb/tb_act_lm_bank.sv
// Self-checking bench for act_lm_bank (CH=4, SEL_W=2, 24-bit chain).
module tb_act_lm_bank;
   localparam int CH      = 4;
   localparam int SEL_W   = 2;
   localparam int CFG_LEN = 24;

   logic                clk = 1'b0;
   logic                clr, cfg_en, cfg_in, cfg_out, cfg_valid;
   logic [CH*SEL_W-1:0] a, b;
   logic [CH-1:0]       out;

   act_lm_bank #(.CH(CH), .SEL_W(SEL_W)) dut (
      .clk(clk), .clr(clr), .a(a), .b(b), .cfg_en(cfg_en), .cfg_in(cfg_in),
      .cfg_out(cfg_out), .cfg_valid(cfg_valid), .out(out)
   );

   always #5 clk = ~clk;

   // kind: 0 = out, 1 = cfg_valid, 2 = cfg_out
   typedef struct {
      string         name;
      int            due;
      int            kind;
      logic [CH-1:0] val;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] exp;
   } vec_t;

   exp_t               sb[$];
   vec_t               vec[6];
   int                 n_checks = 0;
   int                 n_fail   = 0;
   int                 cyc      = 0;
   logic [CFG_LEN-1:0] chain_m;
   bit                 chain_ok = 1'b0;
   logic [CFG_LEN-1:0] img_dff, img_mix;
   logic [2:0]         extra_bits;

   function automatic logic [CFG_LEN-1:0] mk_img(input logic [1:0] m0, m1, m2, m3,
                                                 input logic [3:0] t0, t1, t2, t3);
      return {m3, t3, m2, t2, m1, t1, m0, t0};
   endfunction

   task automatic expect_sig(input string nm, input int lat, input int kind, input logic [CH-1:0] v);
      exp_t e;
      e.name = nm;
      e.due  = cyc + lat;
      e.kind = kind;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic compare(input exp_t e);
      logic [CH-1:0] act;
      case (e.kind)
         0:       act = out;
         1:       act = {3'b000, cfg_valid};
         default: act = {3'b000, cfg_out};
      endcase
      n_checks++;
      if (act !== e.val) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", e.name, cyc, act, e.val);
      end
   endtask

   task automatic drain();
      exp_t keep[$];
      foreach (sb[i]) begin
         if (sb[i].due == cyc) compare(sb[i]);
         else keep.push_back(sb[i]);
      end
      sb = keep;
   endtask

   // Drive one cycle of inputs, check whatever is due now, then advance one edge.
   task automatic apply(input logic c_n, input logic en, input logic din,
                        input logic [7:0] av, input logic [7:0] bv);
      clr = c_n; cfg_en = en; cfg_in = din; a = av; b = bv;
      if (chain_ok) expect_sig("cfg_out_chain", 0, 2, {3'b000, chain_m[CFG_LEN-1]});
      #1;
      drain();
      @(posedge clk);
      #1;
      cyc++;
      if (!c_n) begin
         chain_m  = '0;
         chain_ok = 1'b1;
      end else if (en) begin
         chain_m = {chain_m[CFG_LEN-2:0], din};
      end
   endtask

   // Shift `extra` padding zeros followed by the 24-bit image, MSB first.
   task automatic load(input logic [CFG_LEN-1:0] img, input int extra,
                       input logic [7:0] av, input logic [7:0] bv);
      for (int i = 0; i < extra; i++) apply(1'b1, 1'b1, 1'b0, av, bv);
      for (int i = CFG_LEN - 1; i >= 0; i--) begin
         if (i == CFG_LEN / 2) expect_sig("load_out_gated", 0, 0, 4'b0000);
         if (i == 1) expect_sig("load_valid_pre", 1, 1, (extra > 0) ? 4'b0001 : 4'b0000);
         if (i == 0) expect_sig("load_valid_done", 1, 1, 4'b0001);
         apply(1'b1, 1'b1, img[i], av, bv);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // DFF-mode vectors: m = 1 only when sel == 2'b11
      vec[0] = '{8'hFF, 8'hFF, 4'b1111};
      vec[1] = '{8'h00, 8'h00, 4'b0000};
      vec[2] = '{8'b11_01_11_01, 8'b01_01_10_11, 4'b1001};
      vec[3] = '{8'b10_11_00_01, 8'b01_11_11_10, 4'b0100};
      vec[4] = '{8'h55, 8'hAA, 4'b0000};
      vec[5] = '{8'hFF, 8'h55, 4'b1111};

      img_dff = mk_img(2'b01, 2'b01, 2'b01, 2'b01, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
      img_mix = mk_img(2'b10, 2'b11, 2'b00, 2'b01, 4'b1111, 4'b0010, 4'b0100, 4'b1000);
      extra_bits = 3'b101;

      a = '0; b = '0; clr = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;

      // Reset, with clr dominating an attempted shift
      expect_sig("rst_valid", 1, 1, 4'b0000);
      expect_sig("rst_out", 1, 0, 4'b0000);
      expect_sig("rst_cfg_out", 1, 2, 4'b0000);
      apply(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
      apply(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      expect_sig("idle_out", 0, 0, 4'b0000);
      apply(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);

      // All channels DFF with table 1000, a=b=all ones
      load(img_dff, 0, 8'hFF, 8'hFF);
      expect_sig("dff_valid", 0, 1, 4'b0001);
      expect_sig("dff_out_first", 0, 0, 4'b0000);
      expect_sig("dff_out_latency", 1, 0, 4'b1111);
      apply(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
      foreach (vec[i]) begin
         expect_sig($sformatf("vec%0d", i), 1, 0, vec[i].exp);
         apply(1'b1, 1'b0, 1'b0, vec[i].a, vec[i].b);
      end
      apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

      // Mixed: ch0 TFF 1111, ch1 STICKY 0010, ch2 COMB 0100, ch3 DFF 1000
      load(img_mix, 0, 8'h00, 8'h00);
      expect_sig("mix_valid", 0, 1, 4'b0001);
      expect_sig("mix_out0", 0, 0, 4'b0000);
      apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      expect_sig("mix_tff1_pulse", 0, 0, 4'b0001);
      apply(1'b1, 1'b0, 1'b0, 8'h04, 8'h04);
      expect_sig("mix_tff0_sticky", 0, 0, 4'b0010);
      apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      expect_sig("mix_comb_high", 0, 0, 4'b0111);
      apply(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      expect_sig("mix_comb_low", 0, 0, 4'b0010);
      apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      expect_sig("mix_tff_sticky_hold", 0, 0, 4'b0011);
      apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

      // Shift burst of 3 in mid-operation
      for (int j = 0; j < 3; j++) begin
         expect_sig($sformatf("burst_cfg_out%0d", j), 0, 2, {3'b000, img_mix[CFG_LEN-1-j]});
         expect_sig($sformatf("burst_out%0d", j), 0, 0, 4'b0000);
         if (j == 0) begin
            expect_sig("burst_valid_before", 0, 1, 4'b0001);
            expect_sig("burst_valid_drop", 1, 1, 4'b0000);
         end
         apply(1'b1, 1'b1, extra_bits[j], 8'h04, 8'h04);
      end
      expect_sig("burst_cfg_out_after", 0, 2, {3'b000, img_mix[CFG_LEN-4]});
      expect_sig("burst_valid_after", 0, 1, 4'b0000);
      expect_sig("burst_out_after", 0, 0, 4'b0000);
      expect_sig("burst_out_held", 1, 0, 4'b0000);
      apply(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

      // Reset hit on shift 12, then full reload with one padding bit
      for (int i = 0; i < 12; i++)
         apply((i == 11) ? 1'b0 : 1'b1, 1'b1, img_dff[CFG_LEN-1-i], 8'hFF, 8'hFF);
      expect_sig("clr_mid_valid", 0, 1, 4'b0000);
      expect_sig("clr_mid_cfg_out", 0, 2, 4'b0000);
      expect_sig("clr_mid_out", 0, 0, 4'b0000);
      apply(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
      load(img_dff, 1, 8'hFF, 8'hFF);
      expect_sig("reload_valid", 0, 1, 4'b0001);
      expect_sig("reload_out_first", 0, 0, 4'b0000);
      expect_sig("reload_out", 1, 0, 4'b1111);
      apply(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
      expect_sig("reload_out_hold", 1, 0, 4'b0000);
      apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

      foreach (sb[i]) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s never checked (due cycle %0d)", sb[i].name, sb[i].due);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
